// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-file completer.
// Optional feature macro: APB_SLV_ERR_EN (see apb_regfile_slave.sv).
package apb_slv_pkg;

   // Transfer sequencing states of the completer
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   // Address of the read-only ID register (the last address of the map)
   localparam logic [3:0] ID_ADDR = 4'hF;

   // Largest supported wait-state count and the counter width that holds it
   localparam int MAX_WAIT = 7;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/apb_slv_regbank.sv
// Register bank: (2**ADDR_W - 1) read/write registers plus a constant ID
// register at the all-ones address. Synchronous write, combinational read.
// Optional feature macro: none (the bank itself never raises errors).
module apb_slv_regbank
   import apb_slv_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                DATA_W   = DATA_W_DEF,
   parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int NUM_RW = (2 ** ADDR_W) - 1;

   logic [DATA_W-1:0] regs_q [NUM_RW];
   logic [DATA_W-1:0] regs_d [NUM_RW];

   // Next-state of the storage: only the addressed RW register takes the
   // write; the ID address matches no storage slot, so writes there vanish.
   always_comb begin
      for (int i = 0; i < NUM_RW; i++) begin
         regs_d[i] = regs_q[i];
         if (we && (waddr == ADDR_W'(i))) begin
            regs_d[i] = wdata;
         end
      end
   end

   // Storage flops, cleared by the synchronous active-low reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_RW; i++) begin
         if (!rst_n) begin
            regs_q[i] <= '0;
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read mux: ID constant by default, replaced by any matching RW register
   always_comb begin
      rdata = ID_VALUE;
      for (int i = 0; i < NUM_RW; i++) begin
         if (raddr == ADDR_W'(i)) begin
            rdata = regs_q[i];
         end
      end
   end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 completer in front of a small register file.
//
// Handshake: a transfer begins when PSEL=1 and PENABLE=0 are sampled in IDLE
// (setup phase); address, direction and write data are captured on that
// edge. The following cycles are the access phase: PREADY stays low for
// WAIT_STATES cycles and then is high for exactly one cycle, during which
// PRDATA (reads) and PSLVERR are valid. The transfer completes on the edge
// where PSEL & PENABLE & PREADY are all 1; writes commit on that edge. Dropping
// PSEL before completion abandons the transfer without a write.
//
// Optional feature macro: APB_SLV_ERR_EN. When defined, a write to the ID
// register completes with PSLVERR=1; otherwise PSLVERR is always 0 and such
// writes are silently discarded. WAIT_STATES must be within 0..MAX_WAIT.
module apb_regfile_slave
   import apb_slv_pkg::*;
#(
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                WAIT_STATES = 1,
   parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR
);

   localparam logic [ADDR_W-1:0] ID_SEL = '1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;

   logic              ready;
   logic              bank_we;
   logic [DATA_W-1:0] bank_rdata;

   // Completion cycle: a transfer is in flight, its wait count has run out
   // and the requester is still presenting the access phase.
   assign ready   = (state_q != IDLE) && PSEL && PENABLE && (cnt_q == '0);
   assign bank_we = ready && write_q && (addr_q != ID_SEL);

   // Next-state and capture logic for the transfer sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      case (state_q)
         IDLE: begin
            // PENABLE high without a setup phase is ignored here
            if (PSEL && !PENABLE) begin
               state_d = SETUP;
               addr_d  = PADDR;
               wdata_d = PWDATA;
               write_d = PWRITE;
               cnt_d   = CNT_W'(WAIT_STATES);
            end
         end
         SETUP, ACCESS: begin
            if (!PSEL) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (ready) begin
               state_d = IDLE;
            end else begin
               state_d = ACCESS;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer and capture registers with synchronous active-low reset
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
      end
   end

   apb_slv_regbank #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .ID_VALUE (ID_VALUE)
   ) u_regbank (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (bank_we),
      .waddr (addr_q),
      .wdata (wdata_q),
      .raddr (addr_q),
      .rdata (bank_rdata)
   );

   // APB response drive: data and error only during the completion cycle
   always_comb begin
      PREADY  = ready;
      PRDATA  = (ready && !write_q) ? bank_rdata : '0;
`ifdef APB_SLV_ERR_EN
      PSLVERR = ready && write_q && (addr_q == ID_SEL);
`else
      PSLVERR = 1'b0;
`endif
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave. Three instances share one clock:
// unit 0 with WAIT_STATES=1, unit 1 with 0, unit 2 with 3.
// Optional feature macro: APB_SLV_ERR_EN (changes the expected PSLVERR).
module tb_apb_regfile_slave;

`ifdef APB_SLV_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       presetn;
   logic       psel    [3];
   logic       penable [3];
   logic       pwrite  [3];
   logic [3:0] paddr   [3];
   logic [7:0] pwdata  [3];
   logic [7:0] prdata  [3];
   logic       pready  [3];
   logic       pslverr [3];

   int n_tests = 0;
   int n_fail  = 0;

   apb_regfile_slave #(.WAIT_STATES(1)) u_ws1 (
      .PCLK(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
   );

   apb_regfile_slave #(.WAIT_STATES(0)) u_ws0 (
      .PCLK(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
   );

   apb_regfile_slave #(.WAIT_STATES(3)) u_ws3 (
      .PCLK(clk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable[2]),
      .PWRITE(pwrite[2]), .PADDR(paddr[2]), .PWDATA(pwdata[2]),
      .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
   );

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Called at posedge+1; returns at posedge+1 right after the completion
   // edge, so consecutive calls run back-to-back with no idle cycle.
   // During wait cycles PADDR/PWDATA are corrupted to show they are ignored.
   task automatic xfer(input int u, input logic wr, input logic [3:0] a,
                       input logic [7:0] wd, output logic [7:0] rd,
                       output logic err, output int waits);
      psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr;
      paddr[u] = a;   pwdata[u] = wd;
      @(posedge clk); #1 penable[u] = 1'b1;
      waits = 0;
      forever begin
         @(negedge clk);
         if (pready[u]) break;
         if (waits >= 20) break;
         waits++;
         @(posedge clk); #1;
         paddr[u]  = ~a;
         pwdata[u] = ~wd;
      end
      chk("pready_seen", 32'(pready[u]), 32'd1);
      rd  = prdata[u];
      err = pslverr[u];
      @(posedge clk); #1;
      psel[u] = 1'b0; penable[u] = 1'b0;
   endtask

   task automatic apb_wr(input int u, input logic [3:0] a, input logic [7:0] d,
                         input logic exp_err, input int exp_waits, input string tag);
      logic [7:0] rd;
      logic       err;
      int         waits;
      xfer(u, 1'b1, a, d, rd, err, waits);
      chk({tag, "_err"},   32'(err), 32'(exp_err));
      chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
   endtask

   task automatic apb_rd(input int u, input logic [3:0] a, input logic [7:0] exp_d,
                         input int exp_waits, input string tag);
      logic [7:0] rd;
      logic       err;
      int         waits;
      xfer(u, 1'b0, a, 8'h00, rd, err, waits);
      chk({tag, "_data"},  32'(rd), 32'(exp_d));
      chk({tag, "_err"},   32'(err), 32'd0);
      chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pulses;
      presetn = 1'b0;
      for (int u = 0; u < 3; u++) begin
         psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
         paddr[u] = 4'h0; pwdata[u] = 8'h00;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pready",  32'(pready[0]),  32'd0);
      chk("rst_prdata",  32'(prdata[0]),  32'd0);
      chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
      chk("rst_pready_ws0", 32'(pready[1]), 32'd0);
      @(posedge clk); #1 presetn = 1'b1;

      // Basic writes/reads with one wait state
      apb_wr(0, 4'h1, 8'hAA, 1'b0, 1, "w1");
      apb_wr(0, 4'h2, 8'h55, 1'b0, 1, "w2");
      apb_rd(0, 4'h1, 8'hAA, 1, "r1");
      // Back-to-back reads
      apb_rd(0, 4'h2, 8'h55, 1, "r2");
      apb_rd(0, 4'h3, 8'h00, 1, "r3");
      // ID register
      apb_rd(0, 4'hF, 8'hA5, 1, "rid");
      apb_wr(0, 4'hF, 8'h12, ERR_EN, 1, "wid");
      apb_rd(0, 4'hF, 8'hA5, 1, "rid2");
      apb_rd(0, 4'hE, 8'h00, 1, "r14_clean");
      apb_wr(0, 4'hE, 8'hC3, 1'b0, 1, "w14");
      apb_rd(0, 4'hE, 8'hC3, 1, "r14");

      // PENABLE without setup phase is ignored
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
      paddr[0] = 4'h6; pwdata[0] = 8'h77;
      repeat (3) begin
         @(negedge clk);
         chk("pv_pready", 32'(pready[0]), 32'd0);
         @(posedge clk); #1;
      end
      psel[0] = 1'b0; penable[0] = 1'b0;
      apb_rd(0, 4'h6, 8'h00, 1, "pv_r6");

      // Zero-wait instance
      apb_wr(1, 4'h7, 8'h3C, 1'b0, 0, "z_w7");
      apb_rd(1, 4'h7, 8'h3C, 0, "z_r7");

      // Abort on the three-wait instance
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
      paddr[2] = 4'h4; pwdata[2] = 8'hFF;
      @(posedge clk); #1 penable[2] = 1'b1;
      @(negedge clk);
      chk("ab_pready_first", 32'(pready[2]), 32'd0);
      @(posedge clk); #1;
      psel[2] = 1'b0; penable[2] = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (pready[2]) pulses++;
         @(posedge clk); #1;
      end
      chk("ab_pulses", 32'(pulses), 32'd0);
      apb_rd(2, 4'h4, 8'h00, 3, "ab_r4");
      apb_wr(2, 4'h4, 8'h5A, 1'b0, 3, "w3_w4");
      apb_rd(2, 4'h4, 8'h5A, 3, "w3_r4");

      // Reset during the completion cycle of a write
      apb_wr(0, 4'h5, 8'h99, 1'b0, 1, "rs_w5");
      apb_rd(0, 4'h5, 8'h99, 1, "rs_r5a");
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
      paddr[0] = 4'h5; pwdata[0] = 8'h11;
      @(posedge clk); #1 penable[0] = 1'b1;
      @(posedge clk); #1 presetn = 1'b0;
      @(posedge clk); #1;
      presetn = 1'b1; psel[0] = 1'b0; penable[0] = 1'b0;
      @(negedge clk);
      chk("rs_pready",  32'(pready[0]),  32'd0);
      chk("rs_prdata",  32'(prdata[0]),  32'd0);
      chk("rs_pslverr", 32'(pslverr[0]), 32'd0);
      @(posedge clk); #1;
      apb_rd(0, 4'h5, 8'h00, 1, "rs_r5");
      apb_rd(0, 4'h1, 8'h00, 1, "rs_r1");
      apb_rd(1, 4'h7, 8'h00, 0, "rs_z_r7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- APB3 completer (slave) that answers the team's APB initiator/driver on a 4-bit address, 8-bit data bus.
- Holds a 16-entry × 8-bit register bank:
  - addresses 0x0–0xE are read/write;
  - address 0xF is a read-only ID register.
- Inserts a parameterised number of wait states per transfer and flags illegal accesses on PSLVERR.
- Sits in the testbench/SoC as the peripheral target behind the APB driver.

Parameters:
- ADDR_W, 4, address width (fixed register count 2**ADDR_W).
- DATA_W, 8, data width.
- WAIT_STATES, 1, PREADY-low cycles in every access phase; legal range 0..7.
- ID_VALUE, 8'hA5, constant returned on reads of address 0xF.

Ports:
- PCLK  in  1  single clock; all logic on rising edge.
- PRESETn  in  1  synchronous, active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase qualifier.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  register address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data; valid only while PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0 at a PCLK edge):
  - state=IDLE;
  - all 15 RW registers = 0;
  - PRDATA=0, PREADY=0, PSLVERR=0;
  - wait counter=0.
- FSM states:
  - IDLE → SETUP on PSEL=1 & PENABLE=0.
  - SETUP: latch PADDR/PWRITE/PWDATA; load counter with WAIT_STATES; → ACCESS unconditionally.
  - ACCESS:
    - while counter≠0: PREADY=0, decrement.
    - when counter=0: PREADY=1 for exactly one cycle, PRDATA/PSLVERR driven.
    - → IDLE after the completion edge.
- Latency: with WAIT_STATES=N, PREADY rises N cycles after PENABLE rises (N=0 → zero-wait APB).
- Write commit: the register updates on the PCLK edge where PSEL & PENABLE & PREADY=1, using the latched address/data. Mid-transfer PADDR/PWDATA changes are ignored.
- Read: PRDATA = bank[latched addr] (0xF → ID_VALUE) during the PREADY=1 cycle; 0 at all other times.
- Back-to-back: a new SETUP may be sampled on the cycle immediately after completion; no idle cycle required.
- Abort: PSEL deasserted while in ACCESS → return to IDLE, no write, PREADY stays 0.
- Protocol violation: PENABLE=1 observed in IDLE (no setup phase) → ignored, no state change.
- Reset mid-transfer: transfer dropped, no partial write, all outputs at reset values next cycle.
- Addresses wrap naturally within ADDR_W; there are no out-of-range addresses.

Optional Feature:
- Macro: APB_SLV_ERR_EN.
- Defined:
  - a write to 0xF completes with PSLVERR=1 and no state change;
  - PSLVERR is 0 on all other transfers.
- Undefined:
  - PSLVERR is tied 0;
  - writes to 0xF complete normally but are silently discarded.

Decomposition:
- Package apb_slv_pkg:
  - state enum (IDLE, SETUP, ACCESS);
  - ADDR_W/DATA_W defaults;
  - ID_ADDR = 4'hF;
  - max wait constant 7.
- One natural sub-module, apb_slv_regbank:
  - 15×8 storage with synchronous write enable;
  - combinational read mux including the ID constant.
- The top holds the FSM, wait counter and APB output drive.

Test Plan:
- Write 0x1=AA, write 0x2=55, read 0x1 (WAIT_STATES=1) → PREADY high exactly one cycle after PENABLE; PRDATA=AA; PSLVERR=0.
- Read 0x2 then 0x3 back-to-back with no idle cycle → PRDATA=55, then 00.
- Read 0xF → PRDATA=A5. Write 0xF=12, then read 0xF → A5. PSLVERR on the write is 1 with APB_SLV_ERR_EN defined, 0 without.
- WAIT_STATES=0, write 0x7=3C, then read → PREADY=1 in the first access cycle; PRDATA=3C.
- Start write 0x4=FF (WAIT_STATES=3), drop PSEL after 1 wait cycle, then read 0x4 → 00, and no PREADY pulse on the aborted transfer.
- Write 0x5=99, then assert PRESETn=0 during the ACCESS of a second write 0x5=11, then read 0x5 → 00 (reset cleared the bank, no partial write).
